// File: rtl/atm_balance_arbiter.sv
// atm_balance_arbiter: two-terminal round-robin arbiter in front of a single
// account balance register. Each grant runs IDLE -> EXEC -> RESP; the
// balance is updated once at the EXEC->RESP edge and the response is
// reported with a one-cycle done pulse.
// Optional feature: define ATM_DAILY_LIMIT_EN to enable the cumulative
// daily withdraw cap (DAILY_LIMIT, cleared by limit_clr).
module atm_balance_arbiter #(
  parameter logic [31:0] INIT_BALANCE = 32'h000F4240,
  parameter logic [31:0] DAILY_LIMIT  = 32'd5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  input  logic [31:0] amt0,
  input  logic [31:0] amt1,
  input  logic        limit_clr,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic        ok,
  output logic [31:0] balance_out,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_QUERY    = 2'b01;
  localparam logic [1:0] OP_DEPOSIT  = 2'b10;
  localparam logic [1:0] OP_WITHDRAW = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  done_q, done_d;
  logic        ok_q, ok_d;
  logic [31:0] bal_out_q, bal_out_d;
  logic        prio_q, prio_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] amt_q, amt_d;
  logic [31:0] balance_q, balance_d;
  logic        res_ok_q, res_ok_d;
  logic [31:0] total_q, total_d;

  logic        win;
  logic        eval_ok;
  logic [31:0] eval_bal;
  logic [32:0] dep_sum;
  logic        limit_hit;

`ifdef ATM_DAILY_LIMIT_EN
  logic [32:0] total_sum;
  // Withdraw is refused if it would push the day's total past the cap
  always_comb begin
    total_sum = {1'b0, total_q} + {1'b0, amt_q};
    limit_hit = (total_sum > {1'b0, DAILY_LIMIT});
  end
`else
  logic unused_limit;
  assign unused_limit = ^{limit_clr, DAILY_LIMIT, total_q};
  assign limit_hit    = 1'b0;
`endif

  // Evaluate the latched transaction against the current balance
  always_comb begin
    dep_sum  = {1'b0, balance_q} + {1'b0, amt_q};
    eval_ok  = 1'b0;
    eval_bal = balance_q;
    case (op_q)
      OP_QUERY: eval_ok = 1'b1;
      OP_DEPOSIT: begin
        if (!dep_sum[32]) begin
          eval_ok  = 1'b1;
          eval_bal = dep_sum[31:0];
        end
      end
      OP_WITHDRAW: begin
        if ((amt_q <= balance_q) && !limit_hit) begin
          eval_ok  = 1'b1;
          eval_bal = balance_q - amt_q;
        end
      end
      default: eval_ok = 1'b0;
    endcase
  end

  // Next-state and next-output logic for the arbiter FSM
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    done_d    = '0;
    ok_d      = 1'b0;
    bal_out_d = '0;
    prio_d    = prio_q;
    op_d      = op_q;
    amt_d     = amt_q;
    balance_d = balance_q;
    res_ok_d  = res_ok_q;
    total_d   = total_q;
    win       = (req == 2'b11) ? prio_q : req[1];

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = EXEC;
          gnt_d   = win ? 2'b10 : 2'b01;
          op_d    = win ? op1 : op0;
          amt_d   = win ? amt1 : amt0;
          prio_d  = ~win;
        end
      end
      EXEC: begin
        state_d   = RESP;
        res_ok_d  = eval_ok;
        balance_d = eval_bal;
        if (eval_ok && (op_q == OP_WITHDRAW))
          total_d = total_q + amt_q;
      end
      RESP: begin
        // RESP spans two cycles: the first registers the response so done
        // lands two edges after the grant; the second clears it with gnt.
        if (done_q == 2'b00) begin
          done_d    = gnt_q;
          ok_d      = res_ok_q;
          bal_out_d = balance_q;
        end else begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

`ifdef ATM_DAILY_LIMIT_EN
    if (limit_clr)
      total_d = '0;
`else
    total_d = '0;
`endif
  end

  // All state and registered outputs, asynchronously reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      done_q    <= '0;
      ok_q      <= 1'b0;
      bal_out_q <= '0;
      prio_q    <= 1'b0;
      op_q      <= '0;
      amt_q     <= '0;
      balance_q <= INIT_BALANCE;
      res_ok_q  <= 1'b0;
      total_q   <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      bal_out_q <= bal_out_d;
      prio_q    <= prio_d;
      op_q      <= op_d;
      amt_q     <= amt_d;
      balance_q <= balance_d;
      res_ok_q  <= res_ok_d;
      total_q   <= total_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign ok          = ok_q;
  assign balance_out = bal_out_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_atm_balance_arbiter.sv
// Testbench for atm_balance_arbiter: directed scenarios plus randomized
// rounds, checked by a scoreboard fed from a transaction-level account model.
module tb_atm_balance_arbiter;

  localparam logic [31:0] INIT  = 32'h000F4240;
  localparam logic [31:0] LIMIT = 32'd5000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  op0, op1;
  logic [31:0] amt0, amt1;
  logic        limit_clr;
  logic [1:0]  gnt, done;
  logic        ok, busy;
  logic [31:0] balance_out;

  atm_balance_arbiter #(.INIT_BALANCE(INIT), .DAILY_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset), .req(req), .op0(op0), .op1(op1),
    .amt0(amt0), .amt1(amt1), .limit_clr(limit_clr), .gnt(gnt),
    .done(done), .ok(ok), .balance_out(balance_out), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  term;
    logic        ok;
    logic [31:0] bal;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // account model
  longint unsigned m_bal;
  longint unsigned m_total;
  int              m_prio;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bal   = INIT;
    m_total = 0;
    m_prio  = 0;
  endtask

  // Apply one transaction to the account and queue the expected response
  task automatic model_txn(input int t, input logic [1:0] op, input logic [31:0] amt);
    exp_t e;
    e.term = (t == 1) ? 2'b10 : 2'b01;
    e.ok   = 1'b0;
    case (op)
      2'd1: e.ok = 1'b1;
      2'd2: if (m_bal + amt <= 64'hFFFF_FFFF) begin
              e.ok = 1'b1; m_bal = m_bal + amt;
            end
      2'd3: begin
              e.ok = (amt <= m_bal);
`ifdef ATM_DAILY_LIMIT_EN
              if (m_total + amt > LIMIT) e.ok = 1'b0;
`endif
              if (e.ok) begin
                m_bal   = m_bal - amt;
                m_total = m_total + amt;
              end
            end
      default: e.ok = 1'b0;
    endcase
    e.bal = m_bal[31:0];
    sb.push_back(e);
  endtask

  // Monitor: compare every done pulse against the scoreboard
  always @(negedge clk) begin
    if (done !== 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {30'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_term", {30'd0, done}, {30'd0, e.term});
        chk("gnt_at_done", {30'd0, gnt}, {30'd0, e.term});
        chk("ok", {31'd0, ok}, {31'd0, e.ok});
        chk("balance_out", balance_out, e.bal);
      end
    end else begin
      chk("idle_ok", {31'd0, ok}, 32'd0);
      chk("idle_bal", balance_out, 32'd0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; limit_clr = 1'b0;
    @(negedge clk);
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_done", {30'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    model_reset();
  endtask

  // Issue n0 requests from terminal 0 and n1 from terminal 1 (each 0..2),
  // holding req until the terminal has seen that many done pulses.
  task automatic do_round(input int n0, input int n1,
                          input logic [1:0] o0, input logic [31:0] a0,
                          input logic [1:0] o1, input logic [31:0] a1,
                          input bit rand_clr);
    int r0 = n0, r1 = n1, c0 = 0, c1 = 0, w, cyc;
    while (r0 > 0 || r1 > 0) begin
      if (r0 > 0 && r1 > 0) w = m_prio;
      else w = (r0 > 0) ? 0 : 1;
      if (w == 0) begin model_txn(0, o0, a0); r0--; end
      else        begin model_txn(1, o1, a1); r1--; end
      m_prio = 1 - w;
    end
    @(negedge clk);
    op0 = o0; amt0 = a0; op1 = o1; amt1 = a1;
    req = {(n1 > 0), (n0 > 0)};
    cyc = 0;
    while (req != 2'b00 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (rand_clr) limit_clr = $urandom_range(0, 1);
      if (done[0]) begin c0++; if (c0 >= n0) req[0] = 1'b0; end
      if (done[1]) begin c1++; if (c1 >= n1) req[1] = 1'b0; end
      // inputs of a granted terminal with no further service may wander
      if (gnt[0] && !done[0] && c0 == n0 - 1) begin op0 = 2'($urandom); amt0 = $urandom; end
      if (gnt[1] && !done[1] && c1 == n1 - 1) begin op1 = 2'($urandom); amt1 = $urandom; end
    end
    limit_clr = 1'b0;
    if (req != 2'b00) begin
      chk("round_timeout", {30'd0, req}, 32'd0);
      req = '0;
    end
  endtask

  function automatic logic [31:0] pick_amt();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return $urandom_range(1, 2000);
      2: return $urandom;
      3: return m_bal[31:0] + 32'($urandom_range(0, 1));
      default: return $urandom_range(1, 100000);
    endcase
  endfunction

  initial begin
    reset = 1'b1; req = '0; op0 = '0; op1 = '0; amt0 = '0; amt1 = '0;
    limit_clr = 1'b0;
    model_reset();
    do_reset();

    // Fixed latency of a single query
    model_txn(0, 2'd1, 32'd0);
    m_prio = 1;
    op0 = 2'd1; req = 2'b01;
    @(posedge clk); #1;
    chk("lat_gnt", {30'd0, gnt}, 32'd1);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("lat_done_n1", {30'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("lat_done_n2", {30'd0, done}, 32'd1);
    req = '0;
    @(posedge clk); #1;
    chk("lat_gnt_clr", {30'd0, gnt}, 32'd0);

    // Both request: terminal 0 first after reset
    do_reset();
    do_round(1, 1, 2'd2, 32'd500, 2'd3, 32'd300, 1'b0);

    // Rejected withdraw and deposit overflow
    do_reset();
    do_round(1, 0, 2'd3, 32'd1000001, 2'd0, 32'd0, 1'b0);
    do_round(0, 1, 2'd0, 32'd0, 2'd2, 32'hFFFFFFFF, 1'b0);
    do_round(1, 0, 2'd2, 32'd0, 2'd0, 32'd0, 1'b0);
    do_round(1, 0, 2'd3, 32'd0, 2'd0, 32'd0, 1'b0);

    // Reset during EXEC aborts without a done pulse
    do_reset();
    @(negedge clk);
    op0 = 2'd3; amt0 = 32'd200; req = 2'b01;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("abort_gnt", {30'd0, gnt}, 32'd0);
    chk("abort_done", {30'd0, done}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    req = '0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    do_round(1, 0, 2'd1, 32'd0, 2'd0, 32'd0, 1'b0);

    // Terminal 0 re-requests while terminal 1 waits; op 00 rejected
    do_reset();
    do_round(2, 1, 2'd2, 32'd7, 2'd0, 32'd9, 1'b0);

`ifdef ATM_DAILY_LIMIT_EN
    do_reset();
    do_round(1, 0, 2'd3, 32'd3000, 2'd0, 32'd0, 1'b0);
    do_round(1, 0, 2'd3, 32'd2500, 2'd0, 32'd0, 1'b0);
    @(negedge clk); limit_clr = 1'b1;
    @(negedge clk); limit_clr = 1'b0;
    m_total = 0;
    do_round(1, 0, 2'd3, 32'd2500, 2'd0, 32'd0, 1'b0);
`endif

    // Randomized rounds
    do_reset();
    for (int i = 0; i < 300; i++) begin
      int n0, n1;
      logic [1:0] o0, o1;
      logic [31:0] a0, a1;
      n0 = $urandom_range(0, 2);
      n1 = $urandom_range(0, 2);
      if (n0 == 0 && n1 == 0) n0 = 1;
      o0 = 2'($urandom); o1 = 2'($urandom);
      a0 = pick_amt(); a1 = pick_amt();
`ifdef ATM_DAILY_LIMIT_EN
      do_round(n0, n1, o0, a0, o1, a1, 1'b0);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk); limit_clr = 1'b1;
        @(negedge clk); limit_clr = 1'b0;
        m_total = 0;
      end
`else
      do_round(n0, n1, o0, a0, o1, a1, 1'b1);
`endif
    end

    repeat (6) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/atm_balance_arbiter.md
ATM_BALANCE_ARBITER -- requirements
Module: atm_balance_arbiter

Interface
REQ-001 SHALL have parameter INIT_BALANCE, default 32'h000F4240, account balance loaded at reset.
REQ-002 SHALL have parameter DAILY_LIMIT, default 32'd5000, cumulative withdraw cap; used only under REQ-030.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  2  per-terminal request, bit i = terminal i, held high until done[i].
REQ-006 SHALL have ports op0, op1  input  2 each  opcode per terminal: 00 invalid, 01 query, 10 deposit, 11 withdraw.
REQ-007 SHALL have ports amt0, amt1  input  32 each  unsigned amount per terminal.
REQ-008 SHALL have port limit_clr  input  1  daily-limit counter clear pulse.
REQ-009 SHALL have port gnt  output  2  one-hot grant, registered.
REQ-010 SHALL have port done  output  2  one-cycle completion pulse to the granted terminal.
REQ-011 SHALL have port ok  output  1  transaction accepted; valid only while done != 0.
REQ-012 SHALL have port balance_out  output  32  balance after the transaction; valid while done != 0.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, RESP; IDLE->EXEC on any req bit, EXEC->RESP unconditionally, RESP->IDLE unconditionally.
REQ-015 SHALL, on leaving IDLE, set gnt to the winner and latch its op/amt; later changes to op/amt/req are ignored until RESP.
REQ-016 SHALL arbitrate round-robin: single requester wins; if both request, the terminal not served last wins; after reset terminal 0 has priority.
REQ-017 SHALL, in EXEC, evaluate: query -> ok=1, no change; deposit -> ok=1 and balance+=amt unless the 33-bit sum exceeds 32'hFFFFFFFF (then ok=0, unchanged); withdraw -> ok=1 and balance-=amt unless amt > balance (then ok=0, unchanged); op 00 -> ok=0, unchanged.
REQ-018 SHALL treat amt=0 deposit/withdraw as ok=1 with balance unchanged.
REQ-019 SHALL, in RESP, pulse done[winner] for exactly one cycle with ok and balance_out registered; gnt clears on RESP->IDLE.
REQ-020 SHALL give fixed latency: req sampled high in IDLE at edge N -> gnt high after N, done high after edge N+2, gnt low after N+3.
REQ-021 SHALL treat a req still high in IDLE after its done as a new request, subject to round-robin.
REQ-022 SHALL hold done=0, ok=0, balance_out=0 outside RESP.
REQ-023 SHALL update the balance register only at the EXEC->RESP edge, at most once per transaction.

Reset
REQ-024 SHALL, on reset assertion at any time including mid-transaction, go to IDLE immediately with gnt=0, done=0, ok=0, balance_out=0, busy=0.
REQ-025 SHALL reload balance to INIT_BALANCE, round-robin pointer to terminal 0, daily counter to 0 on reset.
REQ-026 SHALL issue no done pulse for a transaction aborted by reset.

Configuration
REQ-030 SHALL, with macro ATM_DAILY_LIMIT_EN defined, keep a 32-bit withdrawn-total counter: withdraw additionally rejected (ok=0) when total+amt > DAILY_LIMIT; accepted withdraw adds amt; limit_clr high at a clock edge zeroes it (clear wins over a same-cycle add).
REQ-031 SHALL, without ATM_DAILY_LIMIT_EN, omit the counter, ignore limit_clr and DAILY_LIMIT, and apply REQ-017 only.

Verification
REQ-040 Reset, req=01, op0=01 -> gnt=01 next cycle, done=01 two cycles later, ok=1, balance_out=1000000.
REQ-041 req=11, op0=10 amt0=500, op1=11 amt1=300 held -> terminal 0 served first (balance 1000500), terminal 1 next (ok=1, balance 1000200).
REQ-042 Withdraw amt=1000001 from 1000000 -> ok=0, balance_out=1000000; deposit amt=32'hFFFFFFFF -> ok=0, balance unchanged.
REQ-043 Reset asserted in EXEC of a 200 withdraw -> no done, gnt=0 immediately, subsequent query returns 1000000.
REQ-044 With ATM_DAILY_LIMIT_EN: withdraw 3000 ok=1, withdraw 2500 ok=0, pulse limit_clr, withdraw 2500 ok=1, balance_out=994500.
REQ-045 Terminal 0 holds req after done while terminal 1 requests -> terminal 1 granted next; op 00 -> ok=0.
